// File: rtl/mul_result_accumulator.sv
// mul_result_accumulator
// Sequences the 8-bit Booth multiplier (restart pulse, wait for rdy), sums
// N_ACC signed 16-bit products into a saturating signed accumulator and
// queues each finished sum, with its clip flag, into a 2-entry FIFO.
`timescale 1ns/1ps

module mul_result_accumulator #(
  parameter int ACC_W   = 24,
  parameter int N_ACC   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             mul_restart,
  input  logic [15:0]      prod,
  input  logic             prod_rdy,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(N_ACC + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LOW,
    S_WAIT_RDY,
    S_PUSH
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             terr_q, terr_d;
  logic             mul_restart_q;
  logic             busy_q;

  // FIFO storage and bookkeeping
  logic [ACC_W:0]   fifo_mem [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             fifo_full;
  logic             fifo_pop;
  logic             fifo_push;
  logic [ACC_W:0]   fifo_head;

  // Saturating adder: one guard bit catches signed overflow of acc + prod
  logic [ACC_W:0]   sum_wide;
  logic             sum_clip;
  logic [ACC_W-1:0] sum_sat;
  logic             wdog_expired;

  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){prod[15]}}, prod};
  assign sum_clip = sum_wide[ACC_W] != sum_wide[ACC_W-1];
  assign sum_sat  = !sum_clip      ? sum_wide[ACC_W-1:0] :
                    sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;

  // The counter may step one past WD_LAST when WAIT_LOW hands over on its
  // final allowed cycle, hence >= rather than ==.
  assign wdog_expired = wdog_q >= WD_LAST;

  assign fifo_full = count_q == 2'd2;
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = (state_q == S_PUSH) && (!fifo_full || fifo_pop);

  // Next-state and datapath decisions for the batch sequencer
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wdog_d  = wdog_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LAUNCH;
          terr_d  = 1'b0;
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // A rdy still high from the previous product must drop first
        wdog_d = wdog_q + WD_W'(1);
        if (!prod_rdy) begin
          state_d = S_WAIT_RDY;
        end else if (wdog_expired) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        wdog_d = wdog_q + WD_W'(1);
        if (prod_rdy) begin
          acc_d   = sum_sat;
          ovf_d   = ovf_q | sum_clip;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_LAST) ? S_PUSH : S_LAUNCH;
        end else if (wdog_expired) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_PUSH: begin
        if (fifo_push) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers; outputs are registered from the next state so
  // mul_restart is high exactly during LAUNCH and busy mirrors state != IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      wdog_q        <= '0;
      terr_q        <= 1'b0;
      mul_restart_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      wdog_q        <= wdog_d;
      terr_q        <= terr_d;
      mul_restart_q <= (state_d == S_LAUNCH);
      busy_q        <= (state_d != S_IDLE);
    end
  end

  // FIFO entry storage: each slot loads {ovf, acc} when the write pointer selects it
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_slot
    always_ff @(posedge clk) begin
      if (fifo_push && (wr_ptr_q == 1'(gi))) begin
        fifo_mem[gi] <= {ovf_q, acc_q};
      end
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves occupancy unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (fifo_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_head = fifo_mem[rd_ptr_q];

  assign out_valid   = count_q != 2'd0;
  assign out_data    = out_valid ? fifo_head[ACC_W-1:0] : '0;
  assign out_ovf     = out_valid ? fifo_head[ACC_W] : 1'b0;
  assign mul_restart = mul_restart_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mul_result_accumulator.sv
// Bench for mul_result_accumulator: a behavioural multiplier answers each
// restart pulse after LAT cycles with the next queued product; expected
// sums are pushed to a scoreboard and checked as the FIFO is popped.
`timescale 1ns/1ps

module tb_mul_result_accumulator;

  localparam int ACC_W   = 17;
  localparam int N_ACC   = 4;
  localparam int TIMEOUT = 63;
  localparam int LAT     = 17;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             mul_restart;
  logic [15:0]      prod = 16'd0;
  logic             prod_rdy = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int restart_cnt = 0;
  int restart_cyc = 0;
  bit stale = 1'b0;

  logic [15:0]      prod_q[$];
  logic [ACC_W-1:0] exp_data_q[$];
  logic             exp_ovf_q[$];

  mul_result_accumulator #(
    .ACC_W(ACC_W), .N_ACC(N_ACC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mul_restart(mul_restart),
    .prod(prod), .prod_rdy(prod_rdy), .out_data(out_data), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Multiplier model: restart clears rdy (unless modelling a stuck rdy),
  // then rdy rises LAT cycles later with the next product
  initial begin
    int cd;
    cd = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cd = 0;
        prod_rdy = 1'b0;
      end else if (mul_restart) begin
        restart_cnt++;
        restart_cyc = cyc;
        if (!stale) prod_rdy = 1'b0;
        cd = LAT;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && !stale) begin
          prod = (prod_q.size() > 0) ? prod_q.pop_front() : 16'd0;
          prod_rdy = 1'b1;
        end
      end
    end
  end

  // Scoreboard consumer: compare every accepted FIFO head
  initial forever begin
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got data=%h ovf=%b, none expected", out_data, out_ovf);
      end else begin
        logic [ACC_W-1:0] ed;
        logic             eo;
        ed = exp_data_q.pop_front();
        eo = exp_ovf_q.pop_front();
        if (out_data !== ed || out_ovf !== eo) begin
          errors++;
          $display("FAIL fifo_output got data=%h ovf=%b expected data=%h ovf=%b", out_data, out_ovf, ed, eo);
        end else begin
          $display("pop data=%h ovf=%b ok", out_data, out_ovf);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic queue_batch(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3,
                             input bit expect_out);
    logic [15:0] ps[4];
    longint acc;
    bit ov;
    ps = '{p0, p1, p2, p3};
    acc = 0;
    ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prod_q.push_back(ps[i]);
      acc = acc + longint'($signed(ps[i]));
      if (acc > MAXV) begin acc = MAXV; ov = 1'b1; end
      if (acc < MINV) begin acc = MINV; ov = 1'b1; end
    end
    if (expect_out) begin
      exp_data_q.push_back(ACC_W'(acc));
      exp_ovf_q.push_back(ov);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_data_q.size() == 0) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_restarts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (restart_cnt >= target) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  // Runs one batch to completion and checks it finishes and drains
  task automatic run_batch(input string name, input int base);
    bit ok;
    pulse_start();
    wait_idle(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_idle got busy=%b required busy=0", name, busy); end
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_drain got %0d pending required 0", name, exp_data_q.size()); end
    checks++;
    if (restart_cnt - base != N_ACC) begin
      errors++;
      $display("FAIL %s_restarts got %0d required %0d", name, restart_cnt - base, N_ACC);
    end
    $display("batch %s restarts=%0d", name, restart_cnt - base);
  endtask

  task automatic test_reset();
    tick(2);
    @(negedge clk);
    checks += 6;
    if (mul_restart !== 1'b0) begin errors++; $display("FAIL reset_mul_restart got %b required 0", mul_restart); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b required 0", out_ovf); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b required 0", timeout_err); end
    tick(1);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_sum();
    int base;
    out_ready = 1'b1;
    base = restart_cnt;
    queue_batch(16'd100, 16'd200, 16'hFFCE, 16'hFFFF, 1'b1);
    run_batch("basic", base);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got %b required 0", out_valid); end
    tick(1);
  endtask

  task automatic test_saturation();
    int base;
    out_ready = 1'b1;
    base = restart_cnt;
    queue_batch(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    run_batch("sat_pos", base);
    base = restart_cnt;
    queue_batch(16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
    run_batch("sat_clear", base);
    base = restart_cnt;
    queue_batch(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
    run_batch("sat_neg", base);
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    out_ready = 1'b0;
    base = restart_cnt;
    queue_batch(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    queue_batch(16'hFFF6, 16'hFFEC, 16'hFFE2, 16'hFFD8, 1'b1);
    queue_batch(16'd1000, 16'd2000, 16'd3000, 16'hF060, 1'b1);
    pulse_start();
    wait_idle(400, ok);
    pulse_start();
    wait_idle(400, ok);
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_two_held_valid got %b required 1", out_valid); end
    if (out_data !== exp_data_q[0]) begin errors++; $display("FAIL bp_head got %h required %h", out_data, exp_data_q[0]); end
    tick(1);
    pulse_start();
    wait_restarts(base + 3 * N_ACC, 400, ok);
    tick(LAT + 8);
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_stall_busy got %b required 1", busy); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got %b required 1", out_valid); end
    tick(1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_after_pop_busy got %b required 0", busy); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_after_pop_valid got %b required 1", out_valid); end
    if (exp_data_q.size() != 2) begin errors++; $display("FAIL bp_pending got %0d required 2", exp_data_q.size()); end
    tick(1);
    out_ready = 1'b1;
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain got %0d pending required 0", exp_data_q.size()); end
    $display("backpressure restarts=%0d", restart_cnt - base);
    tick(1);
  endtask

  task automatic test_stale_ready();
    int base;
    int elapsed;
    bit seen;
    out_ready = 1'b1;
    stale = 1'b1;
    prod_rdy = 1'b1;
    base = restart_cnt;
    pulse_start();
    seen = 1'b0;
    elapsed = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin seen = 1'b1; elapsed = cyc - restart_cyc; break; end
    end
    checks += 2;
    if (!seen) begin errors++; $display("FAIL stale_timeout_err got 0 required 1"); end
    if (elapsed < TIMEOUT || elapsed > TIMEOUT + 2) begin
      errors++;
      $display("FAIL stale_timeout_delay got %0d cycles required %0d..%0d", elapsed, TIMEOUT, TIMEOUT + 2);
    end
    tick(1);
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL stale_busy got %b required 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_fifo_valid got %b required 0", out_valid); end
    if (restart_cnt - base != 1) begin errors++; $display("FAIL stale_restarts got %0d required 1", restart_cnt - base); end
    $display("stale ready timeout after %0d cycles", elapsed);
    tick(1);
    stale = 1'b0;
    prod_rdy = 1'b0;
    base = restart_cnt;
    queue_batch(16'd5, 16'd6, 16'd7, 16'd8, 1'b1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL stale_clear_err got %b required 0", timeout_err); end
    begin
      bit ok;
      wait_idle(400, ok);
      wait_drain(50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stale_next_batch got %0d pending required 0", exp_data_q.size()); end
    end
  endtask

  task automatic test_reset_midbatch();
    int base;
    bit ok;
    out_ready = 1'b0;
    queue_batch(16'd9, 16'd9, 16'd9, 16'd9, 1'b0);
    pulse_start();
    wait_idle(400, ok);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b required 1", out_valid); end
    tick(1);
    base = restart_cnt;
    queue_batch(16'd11, 16'd22, 16'd33, 16'd44, 1'b0);
    pulse_start();
    wait_restarts(base + 3, 200, ok);
    tick(3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b required 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL rst_async_data got %h required 0", out_data); end
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_async_ovf got %b required 0", out_ovf); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b required 0", busy); end
    if (mul_restart !== 1'b0) begin errors++; $display("FAIL rst_async_restart got %b required 0", mul_restart); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_async_err got %b required 0", timeout_err); end
    prod_q.delete();
    tick(2);
    reset = 1'b0;
    tick(2);
    out_ready = 1'b1;
    base = restart_cnt;
    queue_batch(16'hFFFD, 16'hFFFC, 16'd5, 16'd1000, 1'b1);
    run_batch("after_reset", base);
  endtask

  task automatic test_ignored_start();
    int base;
    bit ok;
    out_ready = 1'b1;
    base = restart_cnt;
    queue_batch(16'd300, 16'hFF38, 16'd50, 16'd7, 1'b1);
    pulse_start();
    wait_restarts(base + 2, 200, ok);
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(400, ok);
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_drain got %0d pending required 0", exp_data_q.size()); end
    tick(40);
    @(negedge clk);
    checks += 3;
    if (restart_cnt - base != N_ACC) begin errors++; $display("FAIL ign_restarts got %0d required %0d", restart_cnt - base, N_ACC); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b required 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ign_valid got %b required 0", out_valid); end
    $display("ignored start restarts=%0d", restart_cnt - base);
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_saturation();
    test_backpressure();
    test_stale_ready();
    test_reset_midbatch();
    test_ignored_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
